// File: rtl/ram_bus_master_pkg.sv
// ============================================================================
// ram_bus_master_pkg : shared state encoding and RAM bus widths
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_bus_master_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_bus_master_if.sv
// ============================================================================
// ram_bus_master_if : CPU request/response and RAM strobe bus bundle
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_bus_master_if
  import ram_bus_master_pkg::*;
#(
  parameter int ADDR_W = ram_bus_master_pkg::ADDR_W,
  parameter int DATA_W = ram_bus_master_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_write;

  logic [ADDR_W-1:0] adress_bus;
  logic [DATA_W-1:0] date_out;
  logic              date_oe;
  logic [DATA_W-1:0] date_in;
  logic              r;
  logic              w;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, date_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_write,
    output adress_bus, date_out, date_oe, r, w
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, date_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write,
    input  adress_bus, date_out, date_oe, r, w
  );

endinterface

`default_nettype wire

// File: rtl/ram_bus_master.sv
// ============================================================================
// ram_bus_master : single-outstanding CPU-to-async-RAM strobe sequencer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bus_master #(
  parameter int ADDR_W      = ram_bus_master_pkg::ADDR_W,
  parameter int DATA_W      = ram_bus_master_pkg::DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_bus_master_if.master bus
);

  import ram_bus_master_pkg::*;

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              alive;
  logic              is_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              ready;
  logic              accept;
  logic              rd_stb;
  logic              wr_stb;
  logic              oe;
  logic              rsp_vld;

  // alive keeps req_ready low until the first edge after reset release
  assign accept = bus.req_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    rd_stb    = 1'b0;
    wr_stb    = 1'b0;
    oe        = 1'b0;
    rsp_vld   = 1'b0;
    case (state)
      IDLE: begin
        ready = alive;
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        oe        = is_write;
        state_nxt = STROBE;
      end
      STROBE: begin
        oe     = is_write;
        rd_stb = !is_write;
        wr_stb = is_write;
        if (wait_cnt == '0) state_nxt = HOLD;
      end
      HOLD: begin
        oe        = is_write;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      is_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        addr_q   <= bus.req_addr;
        is_write <= bus.req_write;
        // write data only moves when date_oe is about to rise
        if (bus.req_write) wdata_q <= bus.req_wdata;
      end
      case (state)
        SETUP: wait_cnt <= WAIT_INIT;
        STROBE: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (!is_write) begin
            rdata_q <= bus.date_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_write  = is_write;
  assign bus.adress_bus = addr_q;
  assign bus.date_out   = wdata_q;
  assign bus.date_oe    = oe;
  assign bus.r          = rd_stb;
  assign bus.w          = wr_stb;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_master.sv
// ============================================================================
// tb_ram_bus_master : directed bench over three wait-state configurations
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bus_master;

  import ram_bus_master_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [2:0]         rv, rwr, rrdy;
  logic [2:0][AW-1:0] raddr;
  logic [2:0][DW-1:0] rwd;
  logic [2:0]         rr, sv, rwo, rs, ws, oe;
  logic [2:0][AW-1:0] ab;
  logic [2:0][DW-1:0] dout, rd;
  bit   [2:0]         cur_rd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instance 0: WAIT_STATES=0, instance 1: 1, instance 2: 3
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;

      ram_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

      ram_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );

      // one-entry RAM model; unwritten addresses read as addr[7:0]^0x3C
      bit          have_wr;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;

      always @(posedge clk) begin
        if (!rst_n) begin
          have_wr <= 1'b0;
        end else if (bus.w) begin
          have_wr <= 1'b1;
          wr_addr <= bus.adress_bus;
          wr_data <= bus.date_out;
        end
      end

      assign bus.date_in   = (have_wr && (bus.adress_bus == wr_addr)) ? wr_data
                                                                       : (bus.adress_bus[DW-1:0] ^ DW'(8'h3C));
      assign bus.req_valid = rv[g];
      assign bus.req_write = rwr[g];
      assign bus.req_addr  = raddr[g];
      assign bus.req_wdata = rwd[g];
      assign bus.rsp_ready = rrdy[g];
      assign rr[g]   = bus.req_ready;
      assign sv[g]   = bus.rsp_valid;
      assign rwo[g]  = bus.rsp_write;
      assign rs[g]   = bus.r;
      assign ws[g]   = bus.w;
      assign oe[g]   = bus.date_oe;
      assign ab[g]   = bus.adress_bus;
      assign dout[g] = bus.date_out;
      assign rd[g]   = bus.rsp_rdata;
    end
  endgenerate

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rs[k] && ws[k]) begin
        failures++;
        $display("FAIL rw_exclusive inst%0d: actual r=1 w=1 required not both", k);
      end
      checks++;
      if (oe[k] && cur_rd[k]) begin
        failures++;
        $display("FAIL oe_on_read inst%0d: actual date_oe=1 required 0", k);
      end
    end
  end

  // Issue one request with rsp_ready=1; cycle n is the period after edge n
  // (edge 0 = acceptance). Counts are gathered over cycles 0..response.
  task automatic run_txn(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output int rcnt, output int wcnt, output int oecnt,
                         output int addr_bad, output int data_bad,
                         output logic [DW-1:0] rdata, output logic rwrite);
    lat = -1; rcnt = 0; wcnt = 0; oecnt = 0; addr_bad = 0; data_bad = 0;
    rdata = '0; rwrite = 1'b0;
    @(negedge clk);
    cur_rd[k] = !wr;
    rv[k] = 1'b1; rwr[k] = wr; raddr[k] = a; rwd[k] = d; rrdy[k] = 1'b1;
    @(negedge clk);
    rv[k] = 1'b0; rwr[k] = !wr; raddr[k] = ~a; rwd[k] = ~d;
    for (int n = 0; n < 40; n++) begin
      if (ab[k] !== a) addr_bad++;
      if (oe[k] && (dout[k] !== d)) data_bad++;
      if (rs[k]) rcnt++;
      if (ws[k]) wcnt++;
      if (oe[k]) oecnt++;
      if (sv[k]) begin
        lat = n; rdata = rd[k]; rwrite = rwo[k];
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cur_rd[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (sv[k]) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, rc, wc, oc, abad, dbad;
    logic [DW-1:0] rdat;
    logic          rwrt;

    checks = 0; failures = 0;
    rv = '0; rwr = '0; rrdy = '0; raddr = '0; rwd = '0; cur_rd = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    vecs[0] = '{1'b1, 15'h1234, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 15'h1234, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 15'h0042, 8'h5A, 8'h00};
    vecs[3] = '{1'b0, 15'h0042, 8'h00, 8'h5A};
    vecs[4] = '{1'b0, 15'h1234, 8'h00, 8'h08};
    vecs[5] = '{1'b1, 15'h7FFF, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 15'h7FFF, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(rr), 0);
    chk("rst_rsp_valid", 32'(sv), 0);
    chk("rst_strobes_oe", 32'({rs, ws, oe}), 0);
    chk("rst_addr", 32'(ab), 0);
    chk("rst_date_out", 32'(dout), 0);
    chk("rst_rdata_rwrite", 32'({rd, rwo}), 0);

    rst_n = 1'b1;
    #1 chk("ready_before_first_edge", 32'(rr), 0);
    @(negedge clk);
    chk("ready_after_first_edge", 32'(rr), 32'h7);

    for (int i = 0; i < 7; i++) begin
      run_txn(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rc, wc, oc, abad, dbad, rdat, rwrt);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_strobe_width", i), vecs[i].wr ? wc : rc, 2);
      chk($sformatf("vec%0d_other_strobe", i), vecs[i].wr ? rc : wc, 0);
      chk($sformatf("vec%0d_oe_cycles", i), oc, vecs[i].wr ? 4 : 0);
      chk($sformatf("vec%0d_addr_stable", i), abad, 0);
      chk($sformatf("vec%0d_rsp_write", i), 32'(rwrt), 32'(vecs[i].wr));
      if (vecs[i].wr) chk($sformatf("vec%0d_date_out", i), dbad, 0);
      else            chk($sformatf("vec%0d_rdata", i), 32'(rdat), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_idle_after", i), 32'({sv[1], rr[1]}), 32'b01);
    end

    run_txn(0, 1'b0, 15'h7FFF, 8'h00, lat, rc, wc, oc, abad, dbad, rdat, rwrt);
    chk("ws0_latency", lat, 3);
    chk("ws0_r_width", rc, 1);
    chk("ws0_rdata", 32'(rdat), 32'hC3);
    chk("ws0_oe_cycles", oc, 0);
    run_txn(2, 1'b0, 15'h7FFF, 8'h00, lat, rc, wc, oc, abad, dbad, rdat, rwrt);
    chk("ws3_latency", lat, 6);
    chk("ws3_r_width", rc, 4);
    chk("ws3_rdata", 32'(rdat), 32'hC3);
    chk("ws3_addr_stable", abad, 0);

    // backpressure: second request held on req_valid throughout
    @(negedge clk);
    cur_rd[1] = 1'b1;
    rv[1] = 1'b1; rwr[1] = 1'b0; raddr[1] = 15'h0100; rrdy[1] = 1'b0;
    @(negedge clk);
    raddr[1] = 15'h0055;
    wait_rsp(1, lat);
    chk("bp_latency", lat, 4);
    chk("bp_rdata_first", 32'(rd[1]), 32'h3C);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(sv[1]), 1);
      chk($sformatf("bp_hold%0d_rdata", i), 32'(rd[1]), 32'h3C);
      chk($sformatf("bp_hold%0d_ready", i), 32'(rr[1]), 0);
      chk($sformatf("bp_hold%0d_addr", i), 32'(ab[1]), 32'h0100);
    end
    rrdy[1] = 1'b1;
    @(negedge clk);
    chk("bp_after_handshake_valid", 32'(sv[1]), 0);
    chk("bp_after_handshake_ready", 32'(rr[1]), 1);
    @(negedge clk);
    rv[1] = 1'b0;
    chk("bp_second_accepted", 32'(rr[1]), 0);
    chk("bp_second_addr", 32'(ab[1]), 32'h0055);
    wait_rsp(1, lat);
    chk("bp_second_latency", lat, 4);
    chk("bp_second_rdata", 32'(rd[1]), 32'h69);
    @(negedge clk);
    cur_rd[1] = 1'b0;

    // reset in the first STROBE cycle of a write
    rv[1] = 1'b1; rwr[1] = 1'b1; raddr[1] = 15'h0ABC; rwd[1] = 8'h77; rrdy[1] = 1'b1;
    @(negedge clk);
    rv[1] = 1'b0;
    chk("rstmid_setup_oe", 32'(oe[1]), 1);
    @(negedge clk);
    chk("rstmid_w_before", 32'(ws[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_w", 32'(ws[1]), 0);
    chk("rstmid_oe", 32'(oe[1]), 0);
    chk("rstmid_rsp_valid", 32'(sv[1]), 0);
    chk("rstmid_ready", 32'(rr[1]), 0);
    chk("rstmid_addr", 32'(ab[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstmid_ready_before_edge", 32'(rr[1]), 0);
    @(negedge clk);
    chk("rstmid_ready_after_edge", 32'(rr[1]), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_rsp%0d", i), 32'({sv[1], ws[1], oe[1]}), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 15, address width matching the RAM address bus [14:0].
REQ-002 The block SHALL have these parameters: DATA_W, default 8, data width (byte).
REQ-003 The block SHALL have these parameters: WAIT_STATES, default 1, extra strobe cycles (range 0..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
  clk  in  1  single clock, all state changes on rising edge
  rst_n  in  1  asynchronous active-low reset
REQ-005 The CPU-side request ports SHALL be:
  req_valid  in  1  request present
  req_ready  out  1  block can accept request
  req_write  in  1  1 = write, 0 = read
  req_addr  in  ADDR_W  target address
  req_wdata  in  DATA_W  write data
REQ-006 The CPU-side response ports SHALL be:
  rsp_valid  out  1  transaction complete
  rsp_ready  in  1  consumer accepts response
  rsp_rdata  out  DATA_W  read data (undefined for writes)
  rsp_write  out  1  echoes req_write of the completed transaction
REQ-007 The RAM-side ports SHALL be:
  adress_bus  out  ADDR_W  address to RAM
  date_out  out  DATA_W  write data to RAM
  date_oe  out  1  tristate enable for date_out (top level resolves inout date_bus)
  date_in  in  DATA_W  read data from RAM
  r  out  1  read strobe, active high
  w  out  1  write strobe, active high

Function
REQ-008 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD and RESP, one transaction at a time.
REQ-009 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, and addr, write and wdata are registered at that edge.
REQ-010 IDLE SHALL go to SETUP on accept; otherwise it stays in IDLE, with r=w=0 and date_oe=0.
REQ-011 SETUP SHALL last 1 cycle: adress_bus is driven; for a write, date_out is driven and date_oe=1; r=w=0.
REQ-012 STROBE SHALL last exactly 1+WAIT_STATES cycles, with r=1 (read) or w=1 (write) for every STROBE cycle; address and data are held stable.
REQ-013 For a read, date_in SHALL be captured into rsp_rdata at the clock edge ending the last STROBE cycle.
REQ-014 HOLD SHALL last 1 cycle with r=w=0; address is held; for a write, date_out and date_oe=1 are held; for a read, date_oe=0.
REQ-015 RESP SHALL assert rsp_valid, with rsp_rdata and rsp_write stable, until rsp_ready; on the rsp_valid && rsp_ready edge the FSM goes to IDLE.
REQ-016 Latency SHALL be as follows: with acceptance at edge 0, rsp_valid is first high in cycle 3+WAIT_STATES after acceptance (WAIT_STATES=1: cycle 4); minimum request spacing is 5+WAIT_STATES cycles.
REQ-017 r and w SHALL never be 1 in the same cycle.
REQ-018 r and w SHALL never be 1 in SETUP, HOLD, RESP or IDLE.
REQ-019 date_oe SHALL be 1 only during SETUP, STROBE and HOLD of a write.
REQ-020 The wait-state counter SHALL be 4 bits, load WAIT_STATES on entering STROBE, decrement each STROBE cycle, and leave STROBE when it equals 0; WAIT_STATES=0 gives a 1-cycle strobe.
REQ-021 req_valid SHALL be ignored outside IDLE, and changes to req_* after acceptance SHALL not affect the transaction in flight.
REQ-022 adress_bus SHALL hold its last value in IDLE and RESP.
REQ-023 date_out SHALL hold its last value whenever date_oe=0.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state=IDLE and r=0, w=0, date_oe=0, rsp_valid=0, req_ready=0 while held, with adress_bus=0, date_out=0, rsp_rdata=0, rsp_write=0 and the wait counter=0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no response generated, and strobes SHALL drop in the same cycle.
REQ-026 After rst_n rises, req_ready SHALL be 1 from the first clock edge.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, SETUP, STROBE, HOLD, RESP) and the bus width constants (ADDR_W=15, DATA_W=8), so that the RAM model and CPU use the same values.
REQ-028 The design SHALL be one flat module with no sub-module; the tristate resolution onto date_bus SHALL be done at the top level.

Verification
REQ-029 The bench SHALL cover a write: WAIT_STATES=1, write addr 0x1234 data 0xA5 -> w high exactly 2 cycles, date_oe high 4 cycles, address 0x1234 stable throughout, rsp_valid in cycle 4 with rsp_write=1.
REQ-030 The bench SHALL cover a read-back: after the write, read addr 0x1234 -> r high 2 cycles, date_oe=0, rsp_rdata=0xA5, rsp_write=0.
REQ-031 The bench SHALL cover WAIT_STATES=0 and 3: a read of addr 0x7FFF -> r width 1 and 4 cycles respectively, with rsp_valid in cycle 3 and cycle 6.
REQ-032 The bench SHALL cover backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until 1 cycle after the rsp handshake.
REQ-033 The bench SHALL cover reset mid-strobe: assert rst_n=0 during a write STROBE -> w, date_oe and rsp_valid are 0 in the same cycle, no response is produced after release, and req_ready=1 after the first edge.
REQ-034 Throughout all scenarios the bench SHALL assert that r and w are never 1 together and that date_oe is never 1 during a read.
